// File: rtl/s_machine_interp_mc.sv
// Multi-cycle S-Machine interpreter: fetches 16-bit instructions over a req/ack
// memory port and executes them against a small register file with zero/carry flags.
module s_machine_interp_mc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              zero,
    output logic              carry,
    output logic              halted,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       inst_q, inst_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic              zero_q, zero_d, carry_q, carry_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              halted_q, halted_d;

    logic [3:0]        opcode;
    logic [1:0]        rd, rs;
    logic [DATA_W-1:0] imm_data;
    logic [ADDR_W-1:0] imm_addr;

    assign opcode   = inst_q[15:12];
    assign rd       = inst_q[11:10];
    assign rs       = inst_q[9:8];
    assign imm_data = DATA_W'(inst_q[7:0]);
    assign imm_addr = inst_q[ADDR_W-1:0];

    logic [DATA_W:0]   alu_wide;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry, alu_op;

    // The extra top bit of alu_wide is the carry-out for ADD/INC and the borrow for SUB.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        alu_wide  = '0;
        alu_carry = 1'b0;
        alu_op    = 1'b1;
        case (opcode)
            OP_INC: begin
                alu_wide  = {1'b0, op_a_q} + (DATA_W+1)'(1);
                alu_carry = alu_wide[DATA_W];
            end
            OP_ADD: begin
                alu_wide  = {1'b0, op_a_q} + {1'b0, op_b_q};
                alu_carry = alu_wide[DATA_W];
            end
            OP_SUB: begin
                alu_wide  = {1'b0, op_a_q} - {1'b0, op_b_q};
                alu_carry = alu_wide[DATA_W];
            end
            OP_OR:   alu_wide = {1'b0, op_a_q | op_b_q};
            OP_AND:  alu_wide = {1'b0, op_a_q & op_b_q};
            OP_XOR:  alu_wide = {1'b0, op_a_q ^ op_b_q};
            default: alu_op   = 1'b0;
        endcase
        alu_res = alu_wide[DATA_W-1:0];
    end

    logic at_boundary;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        regs_d      = regs_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        at_boundary = 1'b0;

        case (state_q)
            ST_IDLE: at_boundary = 1'b1;
            ST_FETCH: begin
                if (mem_req_q && mem_ack) begin
                    inst_d    = mem_rdata[15:0];
                    pc_d      = pc_q + ADDR_W'(1);
                    mem_req_d = 1'b0;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                op_a_d  = regs_q[rd];
                op_b_d  = regs_q[rs];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LD, OP_ST: begin
                        state_d     = ST_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (opcode == OP_ST);
                        mem_addr_d  = imm_addr;
                        mem_wdata_d = (opcode == OP_ST) ? op_a_q : '0;
                    end
                    OP_HALT: begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                    OP_LDI: begin
                        regs_d[rd]  = imm_data;
                        at_boundary = 1'b1;
                    end
                    OP_JMP: begin
                        pc_d        = imm_addr;
                        at_boundary = 1'b1;
                    end
                    OP_BZ: begin
                        if (zero_q) pc_d = imm_addr;
                        at_boundary = 1'b1;
                    end
                    default: begin
                        if (alu_op) begin
                            regs_d[rd] = alu_res;
                            zero_d     = (alu_res == '0);
                            carry_d    = alu_carry;
                        end
                        at_boundary = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_req_q && mem_ack) begin
                    if (!mem_we_q) regs_d[rd] = mem_rdata;
                    at_boundary = 1'b1;
                end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase

        // Instruction boundary: enable decides between the next fetch and IDLE.
        if (at_boundary) begin
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
            if (enable) begin
                state_d    = ST_FETCH;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_d;
            end else begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            inst_q      <= '0;
            // NOTE: the register file is only NREG words of flops, so it is cleared with everything else.
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            regs_q      <= regs_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign halted    = halted_q;
    assign dbg_data  = regs_q[dbg_sel];

endmodule

// File: tb/tb_s_machine_interp_mc.sv
// Bench for s_machine_interp_mc: table of ALU vectors plus multi-cycle sequences,
// driven from a memory model that scoreboards every acknowledged access.
module tb_s_machine_interp_mc;

    localparam logic [3:0] O_LDI = 4'h0, O_LD = 4'h1, O_INC = 4'h2, O_ST = 4'h3;
    localparam logic [3:0] O_ADD = 4'h4, O_SUB = 4'h5, O_OR = 4'h6, O_AND = 4'h7;
    localparam logic [3:0] O_XOR = 4'h8, O_JMP = 4'h9, O_BZ = 4'hA, O_NOP = 4'hC;
    localparam logic [3:0] O_HALT = 4'hF;

    logic        clk = 1'b0, rst_n = 1'b1, enable = 1'b0, mem_ack = 1'b0;
    logic        mem_req, mem_we, zero, carry, halted;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_wdata, dbg_data;
    logic [15:0] mem_rdata = '0;
    logic [1:0]  dbg_sel = '0;

    s_machine_interp_mc #(.DATA_W(16), .ADDR_W(8), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .zero(zero), .carry(carry), .halted(halted),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic        chk_wdata;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b, r;
        logic        z, c;
    } vec_t;

    acc_t        sb_q[$];
    logic [15:0] mem [256];
    int          n_cmp = 0, n_fail = 0;
    int          data_delay = 0, slow_base = 256, n_stray = 0;
    bit          stall_en = 0, stray_en = 0;
    logic [7:0]  stall_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reg(input string name, input int idx, input logic [15:0] exp);
        dbg_sel = idx[1:0];
        #1;
        check(name, dbg_data, exp);
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = enc(O_HALT, 0, 0, 0);
        sb_q.delete();
    endtask

    task automatic push_acc(input logic we, input logic [7:0] a, input logic chk, input logic [15:0] wd);
        acc_t e;
        e.we = we; e.addr = a; e.chk_wdata = chk; e.wdata = wd;
        sb_q.push_back(e);
    endtask

    task automatic push_fetch(input logic [7:0] a);
        push_acc(1'b0, a, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    task automatic wait_fetch(input logic [7:0] a, output int cyc);
        cyc = 0;
        while (!(mem_req && !mem_we && mem_addr == a) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!(mem_req && !mem_we && mem_addr == a)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL fetch_wait: no fetch of %h within 200 cycles, required one", a);
        end
    endtask

    task automatic wait_halt();
        int c = 0;
        while (!halted && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    // Memory responder: acks on the negedge so the DUT samples ack/rdata on the next posedge.
    initial begin
        int   cnt = 0;
        bit   last_stray = 0;
        acc_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0; cnt = 0; last_stray = 0;
            end else begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    cnt = 0;
                    if (last_stray) last_stray = 0;
                    else if (stray_en && !mem_req) begin
                        mem_ack    = 1'b1;
                        mem_rdata  = 16'hF5A5;
                        last_stray = 1;
                        n_stray++;
                    end
                end
                if (!mem_ack && mem_req && !(stall_en && mem_addr == stall_addr)) begin
                    if (cnt >= ((int'(mem_addr) >= slow_base) ? data_delay : 0)) begin
                        mem_ack = 1'b1;
                        if (sb_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL sb_extra: got access we=%0b addr=%h, required none", mem_we, mem_addr);
                        end else begin
                            e = sb_q.pop_front();
                            check("sb_we", mem_we, e.we);
                            check("sb_addr", mem_addr, e.addr);
                            if (e.chk_wdata) check("sb_wdata", mem_wdata, e.wdata);
                        end
                        if (mem_we) mem[mem_addr] = mem_wdata;
                        else        mem_rdata = mem[mem_addr];
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    vec_t vt[11];
    int   c, wcyc;

    initial begin
        vt[0]  = '{O_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vt[1]  = '{O_ADD, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0};
        vt[2]  = '{O_ADD, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1};
        vt[3]  = '{O_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
        vt[4]  = '{O_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1};
        vt[5]  = '{O_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0};
        vt[6]  = '{O_AND, 16'hFF00, 16'h00FF, 16'h0000, 1'b1, 1'b0};
        vt[7]  = '{O_XOR, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0};
        vt[8]  = '{O_INC, 16'h7FFF, 16'h0003, 16'h8000, 1'b0, 1'b0};
        vt[9]  = '{O_NOP, 16'h1234, 16'h0003, 16'h1234, 1'b1, 1'b1};
        vt[10] = '{O_LDI, 16'h1234, 16'h0003, 16'h0000, 1'b1, 1'b1};

        // Reset values
        clear_mem();
        #1 rst_n = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_pc", pc, 8'h00);
        check("rst_flags", {zero, carry, halted}, 3'b000);
        for (int i = 0; i < 4; i++) check_reg("rst_reg", i, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-FETCH while ack is withheld
        clear_mem();
        mem[8'h00] = enc(O_JMP, 0, 0, 8'h10);
        stall_addr = 8'h10;
        stall_en   = 1;
        push_fetch(8'h00);
        do_reset();
        enable = 1'b1;
        wait_fetch(8'h10, c);
        repeat (3) @(negedge clk);
        check("stall_req", mem_req, 1'b1);
        check("stall_addr", mem_addr, 8'h10);
        check("stall_pc", pc, 8'h10);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req", mem_req, 1'b0);
        check("midrst_pc", pc, 8'h00);
        check("midrst_addr", mem_addr, 8'h00);
        stall_en = 0;
        push_fetch(8'h00);
        push_fetch(8'h10);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_req", mem_req, 1'b1);
        check("restart_addr", mem_addr, 8'h00);
        wait_halt();
        check("restart_pc", pc, 8'h11);
        check("restart_sb_empty", sb_q.size(), 0);

        // LDI/ADD/SUB/HALT program, zero-wait memory
        clear_mem();
        mem[0] = enc(O_LDI, 1, 0, 8'h05);
        mem[1] = enc(O_LDI, 3, 0, 8'h01);
        mem[2] = enc(O_ADD, 1, 3, 8'h00);
        mem[3] = enc(O_SUB, 1, 3, 8'h00);
        for (int i = 0; i < 5; i++) push_fetch(8'(i));
        do_reset();
        enable = 1'b1;
        wait_fetch(8'h02, c);
        wait_fetch(8'h03, c);
        check("alu_latency", c, 3);
        check_reg("add_r1", 1, 16'h0006);
        wait_halt();
        check_reg("sub_r1", 1, 16'h0005);
        check_reg("prog_r3", 3, 16'h0001);
        check("prog_flags", {zero, carry}, 2'b00);
        check("prog_pc", pc, 8'h05);
        check("prog_sb_empty", sb_q.size(), 0);

        // INC wrap to zero, then BZ taken
        clear_mem();
        mem[0]     = enc(O_LD, 0, 0, 8'h80);
        mem[1]     = enc(O_INC, 0, 0, 8'h00);
        mem[2]     = enc(O_BZ, 0, 0, 8'h20);
        mem[3]     = enc(O_LDI, 3, 0, 8'h77);
        mem[8'h80] = 16'hFFFF;
        push_fetch(8'h00); push_acc(1'b0, 8'h80, 1'b0, '0);
        push_fetch(8'h01); push_fetch(8'h02); push_fetch(8'h20);
        do_reset();
        enable = 1'b1;
        wait_fetch(8'h20, c);
        check("bz_pc", pc, 8'h20);
        check_reg("inc_r0", 0, 16'h0000);
        check("inc_flags", {zero, carry}, 2'b11);
        wait_halt();
        check("bz_halt_pc", pc, 8'h21);
        check("bz_sb_empty", sb_q.size(), 0);

        // ST then LD with three wait cycles on each data access
        clear_mem();
        mem[0]     = enc(O_LDI, 2, 0, 8'hAA);
        mem[1]     = enc(O_ST, 2, 0, 8'h40);
        mem[2]     = enc(O_LD, 0, 0, 8'h40);
        mem[8'h40] = 16'h1111;
        slow_base  = 8'h40;
        data_delay = 3;
        push_fetch(8'h00); push_fetch(8'h01); push_acc(1'b1, 8'h40, 1'b1, 16'h00AA);
        push_fetch(8'h02); push_acc(1'b0, 8'h40, 1'b0, '0); push_fetch(8'h03);
        do_reset();
        enable = 1'b1;
        wait_fetch(8'h01, c);
        c = 0;
        while (!(mem_req && mem_we) && c < 50) begin
            @(negedge clk);
            c++;
        end
        wcyc = 0;
        while (mem_req && mem_we && wcyc < 20) begin
            check("st_wdata", mem_wdata, 16'h00AA);
            check("st_addr", mem_addr, 8'h40);
            wcyc++;
            @(negedge clk);
        end
        check("st_req_cycles", wcyc, 4);
        wait_fetch(8'h02, c);
        wait_fetch(8'h03, c);
        check("ld_latency", c, 7);
        check_reg("ld_r0", 0, 16'h00AA);
        check("st_mem", mem[8'h40], 16'h00AA);
        wait_halt();
        check("ldst_flags", {zero, carry}, 2'b00);
        check("ldst_sb_empty", sb_q.size(), 0);
        slow_base  = 256;
        data_delay = 0;

        // SUB borrow, BZ not taken, XOR self-clear
        clear_mem();
        mem[0] = enc(O_LDI, 0, 0, 8'h03);
        mem[1] = enc(O_LDI, 1, 0, 8'h05);
        mem[2] = enc(O_SUB, 0, 1, 8'h00);
        mem[3] = enc(O_BZ, 0, 0, 8'h30);
        mem[4] = enc(O_XOR, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) push_fetch(8'(i));
        do_reset();
        enable = 1'b1;
        wait_fetch(8'h03, c);
        check_reg("sub_borrow_r0", 0, 16'hFFFE);
        check("sub_borrow_flags", {zero, carry}, 2'b01);
        wait_fetch(8'h04, c);
        check("bz_not_taken_pc", pc, 8'h04);
        wait_halt();
        check_reg("xor_r0", 0, 16'h0000);
        check_reg("xor_r1", 1, 16'h0005);
        check("xor_flags", {zero, carry}, 2'b10);
        check("subxor_sb_empty", sb_q.size(), 0);

        // JMP 0xFF, NOP wraps pc, stray acks in DECODE, enable dropped mid-instruction
        clear_mem();
        mem[8'h00] = enc(O_JMP, 0, 0, 8'hFF);
        mem[8'hFF] = enc(O_NOP, 0, 0, 8'h00);
        push_fetch(8'h00);
        push_fetch(8'hFF);
        stray_en = 1;
        n_stray  = 0;
        do_reset();
        enable = 1'b1;
        wait_fetch(8'hFF, c);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        check("wrap_pc", pc, 8'h00);
        check("wrap_idle_req", mem_req, 1'b0);
        check("wrap_halted", halted, 1'b0);
        check("wrap_flags", {zero, carry}, 2'b00);
        for (int i = 0; i < 4; i++) check_reg("stray_reg", i, 16'h0000);
        check("stray_pulses", n_stray, 2);
        check("wrap_sb_empty", sb_q.size(), 0);
        stray_en = 0;

        // Table of ALU vectors; INC of 0xFFFF first leaves zero=1, carry=1
        for (int i = 0; i < 11; i++) begin
            clear_mem();
            mem[0]     = enc(O_LD, 2, 0, 8'h82);
            mem[1]     = enc(O_INC, 2, 0, 8'h00);
            mem[2]     = enc(O_LD, 0, 0, 8'h80);
            mem[3]     = enc(O_LD, 1, 0, 8'h81);
            mem[4]     = enc(vt[i].op, 0, 1, 8'h00);
            mem[8'h80] = vt[i].a;
            mem[8'h81] = vt[i].b;
            mem[8'h82] = 16'hFFFF;
            push_fetch(8'h00); push_acc(1'b0, 8'h82, 1'b0, '0);
            push_fetch(8'h01); push_fetch(8'h02); push_acc(1'b0, 8'h80, 1'b0, '0);
            push_fetch(8'h03); push_acc(1'b0, 8'h81, 1'b0, '0);
            push_fetch(8'h04); push_fetch(8'h05);
            do_reset();
            enable = 1'b1;
            wait_halt();
            check_reg($sformatf("vec%0d_r0", i), 0, vt[i].r);
            check($sformatf("vec%0d_zero", i), zero, vt[i].z);
            check($sformatf("vec%0d_carry", i), carry, vt[i].c);
            check($sformatf("vec%0d_pc", i), pc, 8'h06);
            check($sformatf("vec%0d_sb_empty", i), sb_q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/s_machine_interp_mc.md
Name: s_machine_interp_mc

Overview:
Multi-cycle, parametrised S-Machine instruction interpreter. It is the next generation of the single-cycle interpreter.
- Fetches its own 16-bit instructions from unified memory over a req/ack handshake.
- Executes against a parametrised register file with zero/carry flags.
- Adds LD/ST, JMP, BZ and HALT. Sits between the memory block and the top-level CPU wrapper.

Parameters:
DATA_W, 16, register/ALU/memory data width; must be >= 16.
ADDR_W, 8, memory address and PC width; must be <= 8.
NREG, 4, register count; fixed at 4 (2-bit register select).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  run permission, sampled at instruction boundary
mem_req  output  1  memory request, held until acknowledged
mem_we  output  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  store data
mem_rdata  input  DATA_W  read data, valid in the cycle mem_ack is high
mem_ack  input  1  single-cycle acknowledge
pc  output  ADDR_W  program counter
zero  output  1  zero flag
carry  output  1  carry/borrow flag
halted  output  1  high in HALT state
dbg_sel  input  2  register select for debug readout
dbg_data  output  DATA_W  combinational readout of reg[dbg_sel]

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-handshake):
  - state = IDLE; pc, registers, zero, carry, inst_reg = 0.
  - mem_req, mem_we, halted = 0; mem_addr, mem_wdata = 0.
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm8. imm8 is zero-extended to DATA_W; for addresses, imm8[ADDR_W-1:0] is used.
- Opcodes:
  - 0 LDI: rd = imm.
  - 1 LD: rd = mem[imm].
  - 2 INC: rd = rd + 1.
  - 3 ST: mem[imm] = rd.
  - 4 ADD: rd = rd + rs.
  - 5 SUB: rd = rd - rs.
  - 6 OR, 7 AND, 8 XOR: rd = rd op rs.
  - 9 JMP: pc = imm.
  - A BZ: pc = imm if zero == 1.
  - F HALT.
  - B-E: NOP.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
  - IDLE: mem_req = 0. Goes to FETCH when enable = 1.
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = pc. On mem_ack: inst_reg = mem_rdata[15:0], pc = pc + 1 (mod 2^ADDR_W), then DECODE.
  - DECODE: 1 cycle; operands latched; then EXEC.
  - EXEC: ALU ops, LDI, JMP, BZ and NOP complete here, then IDLE if enable = 0, else FETCH. LD/ST go to MEM. HALT goes to HALT.
  - MEM: mem_req = 1, mem_addr = imm, mem_we = 1 for ST. On mem_ack: LD writes rd; then FETCH or IDLE (by enable).
  - HALT: halted = 1. Exits only via reset.
- Latency, zero-wait memory (ack in first request cycle):
  - ALU/LDI/JMP/BZ/NOP: 3 cycles.
  - LD/ST: 4 cycles.
  - Each wait cycle extends FETCH or MEM by 1.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req = 1 and ack has not been seen.
  - mem_req deasserts in the cycle after ack unless the next state also requests. FETCH immediately after MEM re-asserts mem_req with the new address.
  - mem_ack while mem_req = 0 is ignored.
- Arithmetic:
  - All results are modulo 2^DATA_W.
  - ADD: carry = carry-out.
  - SUB: carry = 1 iff rd < rs (unsigned borrow).
  - INC: carry = 1 on wrap from all-ones to 0.
  - OR/AND/XOR: carry = 0.
  - zero = (result == 0) for opcodes 2 and 4-8 only. LDI, LD, ST, jumps and NOP leave both flags unchanged.
- rd == rs is legal; the operand is read before write.
- enable deasserted mid-instruction: the current instruction completes; the FSM stops in IDLE at the next boundary.
- PC wraps from 2^ADDR_W - 1 to 0.

Test Plan:
- Reset mid-FETCH, with mem_req = 1 and ack withheld -> mem_req drops immediately, pc = 0, state IDLE. After rst_n rises with enable = 1, fetch restarts at addr 0.
- Program LDI r1,5; LDI r3,1; ADD r1,r3; SUB r1,r3; HALT, zero-wait memory -> dbg r1 = 6 then 5, zero = 0, carry = 0 after SUB, halted = 1, pc = 5.
- DATA_W = 16, r0 = 0xFFFF, INC r0 -> r0 = 0x0000, zero = 1, carry = 1. Then BZ 0x20 -> pc = 0x20.
- ST r2 (0x00AA) to 0x40, then LD r0 from 0x40, with ack delayed 3 cycles each -> mem_wdata = 0x00AA stable across all 4 request cycles, mem_we = 1; r0 = 0x00AA; LD total 7 cycles.
- SUB with r0 = 3, r1 = 5 (SUB r0,r1) -> r0 = 0xFFFE, carry = 1, zero = 0. Then XOR r0,r0 -> r0 = 0, zero = 1, carry = 0.
- JMP 0xFF, NOP at 0xFF -> pc wraps to 0x00. Stray mem_ack pulsed in DECODE -> no state or register change.
